// File: rtl/mccpu_if.sv
// Shared memory port of the multi-cycle core: one request/ready handshake
// carries instruction fetches, loads and stores.
interface mccpu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-subset core with a single wait-stated memory port.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   BOOT   | first cycle after reset, launches the first fetch
//   FETCH  | instruction request outstanding, IR/PC update on ready
//   DECODE | operand read, immediate extension, legality check
//   EXEC   | ALU op, address calc, branch/jump resolution
//   MEM    | load/store request outstanding
//   WB     | register write-back of ALU result or loaded data
//   TRAP   | absorbing error state, left only through reset
module mccpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] SP_INIT  = 32'h0000_2ffc
) (
    input  logic        clk,
    input  logic        rst,
    mccpu_if.master     bus,
    output logic [31:0] PC,
    output logic        retire,
    output logic        trap,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [2:0]  state;
    logic [31:0] ir, a, b, imm_ext, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];

    logic is_r, is_addu, is_subu, is_and, is_or, is_slt, is_sll, is_jr;
    logic is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic is_alu, is_mem, legal;

    assign is_r    = (op == OP_R);
    assign is_addu = is_r && (funct == FN_ADDU);
    assign is_subu = is_r && (funct == FN_SUBU);
    assign is_and  = is_r && (funct == FN_AND);
    assign is_or   = is_r && (funct == FN_OR);
    assign is_slt  = is_r && (funct == FN_SLT);
    assign is_sll  = is_r && (funct == FN_SLL);
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_addi = (op == OP_ADDI);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);

    assign is_alu = is_addu | is_subu | is_and | is_or | is_slt | is_sll | is_addi | is_ori;
    assign is_mem = is_lw | is_sw;
    assign legal  = is_alu | is_mem | is_beq | is_bne | is_j | is_jal | is_jr;

    // ori is the only zero-extended immediate in the subset
    logic [31:0] imm_dec;
    assign imm_dec = is_ori ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};

    // ALU result for the EXEC state of arithmetic/logic instructions
    logic [31:0] alu_res;
    always_comb begin
        alu_res = 32'h0;
        if (is_addu)      alu_res = a + b;
        else if (is_subu) alu_res = a - b;
        else if (is_and)  alu_res = a & b;
        else if (is_or)   alu_res = a | b;
        else if (is_slt)  alu_res = {31'h0, ($signed(a) < $signed(b))};
        else if (is_sll)  alu_res = b << shamt;
        else if (is_addi) alu_res = a + imm_ext;
        else if (is_ori)  alu_res = a | imm_ext;
    end

    logic [31:0] eff_addr;
    logic        taken;
    logic [31:0] npc;

    assign eff_addr = a + imm_ext;
    assign taken    = (is_beq && (a == b)) || (is_bne && (a != b));

    // next PC for control-flow instructions; PC already points past the branch
    always_comb begin
        npc = PC;
        if (is_j || is_jal)
            npc = {PC[31:28], ir[25:0], 2'b00};
        else if (is_jr)
            npc = a;
        else if (taken)
            npc = PC + {imm_ext[29:0], 2'b00};
    end

    // register-file write port: WB stage, or link register during jal EXEC
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'h0;
        if (state == S_WB) begin
            rf_we    = 1'b1;
            rf_waddr = is_r ? rd : rt;
            rf_wdata = is_lw ? mdr : alu_out;
        end else if (state == S_EXEC && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = PC;
        end
    end

    // register file; reset also cancels a write-back in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 29) ? SP_INIT : 32'h0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign reg_data = (reg_sel == 5'd0) ? 32'h0 : regs[reg_sel];

    // control FSM, datapath registers and registered memory-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_BOOT;
            PC            <= RESET_PC;
            ir            <= 32'h0;
            a             <= 32'h0;
            b             <= 32'h0;
            imm_ext       <= 32'h0;
            alu_out       <= 32'h0;
            mdr           <= 32'h0;
            retire        <= 1'b0;
            trap          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_BOOT: begin
                    state        <= S_FETCH;
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= PC;
                end
                S_FETCH: begin
                    if (bus.mem_req && bus.mem_ready) begin
                        ir          <= bus.mem_rdata;
                        PC          <= PC + 32'd4;
                        bus.mem_req <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    imm_ext <= imm_dec;
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (is_alu) begin
                        alu_out <= alu_res;
                        state   <= S_WB;
                    end else if (is_mem) begin
                        if (eff_addr[1:0] != 2'b00) begin
                            trap  <= 1'b1;
                            state <= S_TRAP;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_sw;
                            bus.mem_addr  <= eff_addr;
                            bus.mem_wdata <= b;
                            state         <= S_MEM;
                        end
                    end else begin
                        PC           <= npc;
                        retire       <= 1'b1;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= npc;
                        state        <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.mem_req && bus.mem_ready) begin
                        if (is_lw) begin
                            mdr         <= bus.mem_rdata;
                            bus.mem_req <= 1'b0;
                            state       <= S_WB;
                        end else begin
                            // store done: go straight into the next fetch
                            retire       <= 1'b1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= PC;
                            state        <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    retire       <= 1'b1;
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= PC;
                    state        <= S_FETCH;
                end
                S_TRAP: begin
                    bus.mem_req <= 1'b0;
                end
                default: begin
                    trap        <= 1'b1;
                    bus.mem_req <= 1'b0;
                    state       <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mccpu.sv
// Directed bench for mccpu: small programs in a wait-state memory model,
// checked against hand-computed register, bus and cycle-count values.
module tb_mccpu;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int          PB  = 32'h3000 >> 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] PC, reg_data;
    logic        retire, trap;

    mccpu_if bus();

    mccpu #(.RESET_PC(RPC), .SP_INIT(32'h0000_2ffc)) dut (
        .clk(clk), .rst(rst), .bus(bus), .PC(PC), .retire(retire),
        .trap(trap), .reg_sel(reg_sel), .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    // memory model: image copied in during reset, wait_n stall cycles per access
    logic [31:0] img [4096];
    logic [31:0] mem [4096];
    logic [3:0]  wait_n = 4'd0;
    logic [3:0]  wcnt;

    assign bus.mem_ready = (wcnt >= wait_n);
    assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
            wcnt <= 4'd0;
        end else begin
            if (bus.mem_req && bus.mem_ready && bus.mem_we)
                mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
            if (!bus.mem_req || bus.mem_ready) wcnt <= 4'd0;
            else wcnt <= wcnt + 4'd1;
        end
    end

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // observers sampled on the falling edge
    logic        mon_clr = 1'b1;
    int          rcount, nfetch, ndone, st_cycles;
    int          ret_cyc [16];
    logic [31:0] fa [16];
    logic [31:0] st_addr, st_wdata;
    logic        st_unstable;

    always @(negedge clk) begin
        if (mon_clr) begin
            rcount = 0; nfetch = 0; ndone = 0; st_cycles = 0;
            st_addr = 32'h0; st_wdata = 32'h0; st_unstable = 1'b0;
        end else begin
            if (retire) begin
                if (rcount < 16) ret_cyc[rcount] = cyc;
                rcount++;
            end
            if (bus.mem_req && bus.mem_we) begin
                if (st_cycles == 0) begin
                    st_addr  = bus.mem_addr;
                    st_wdata = bus.mem_wdata;
                end else if (bus.mem_addr != st_addr || bus.mem_wdata != st_wdata) begin
                    st_unstable = 1'b1;
                end
                st_cycles++;
            end
            if (bus.mem_req && bus.mem_ready) begin
                ndone++;
                if (!bus.mem_we) begin
                    if (nfetch < 16) fa[nfetch] = bus.mem_addr;
                    nfetch++;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        reg_sel = sel;
        #1;
        check(tag, reg_data, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 32'h0;
    endtask

    task automatic enter_reset(input logic [3:0] w);
        rst     = 1'b0;
        mon_clr = 1'b1;
        wait_n  = w;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        mon_clr = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic wait_retires(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rcount < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 32'(rcount >= n), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // reset values and first fetch; ALU program
        clear_img();
        img[PB+0] = 32'h3401_0005; // ori  $1,$0,5
        img[PB+1] = 32'h2022_FFF9; // addi $2,$1,-7
        img[PB+2] = 32'h0041_182A; // slt  $3,$2,$1
        img[PB+3] = 32'h0001_20C0; // sll  $4,$1,3
        img[PB+4] = 32'hFC00_0000; // illegal, parks the core
        enter_reset(4'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_pc", PC, RPC);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check_reg("rst_sp", 5'd29, 32'h0000_2ffc);
        check_reg("rst_r1", 5'd1, 32'h0);
        release_reset();
        tick();
        check("boot_req", 32'(bus.mem_req), 32'd1);
        check("boot_addr", bus.mem_addr, RPC);
        check("boot_we", 32'(bus.mem_we), 32'd0);
        wait_retires("p1_retire_timeout", 4, 80);
        check("p1_cycles", 32'(ret_cyc[3] - 1), 32'd16);
        repeat (6) tick();
        check("p1_retire_count", 32'(rcount), 32'd4);
        check_reg("p1_r1", 5'd1, 32'd5);
        check_reg("p1_r2", 5'd2, 32'hFFFF_FFFE);
        check_reg("p1_r3", 5'd3, 32'd1);
        check_reg("p1_r4", 5'd4, 32'd40);

        // store then load with two wait cycles on every access
        clear_img();
        img[2]    = 32'hDEAD_BEEF;
        img[PB+0] = 32'h3401_0005; // ori $1,$0,5
        img[PB+1] = 32'hAC01_0008; // sw  $1,8($0)
        img[PB+2] = 32'h8C05_0008; // lw  $5,8($0)
        img[PB+3] = 32'hFC00_0000;
        enter_reset(4'd2);
        release_reset();
        wait_retires("p2_retire_timeout", 3, 120);
        check("p2_st_addr", st_addr, 32'd8);
        check("p2_st_wdata", st_wdata, 32'd5);
        check("p2_st_cycles", 32'(st_cycles), 32'd3);
        check("p2_st_stable", 32'(st_unstable), 32'd0);
        check("p2_cycles", 32'(ret_cyc[2] - ret_cyc[0]), 32'd17);
        check("p2_mem8", mem[2], 32'd5);
        check_reg("p2_r5", 5'd5, 32'd5);

        // branches and jumps
        clear_img();
        img[PB+0] = 32'h1400_0005; // bne $0,$0,+5 (not taken)
        img[PB+1] = 32'h0800_0010; // j   0x40
        img[16]   = 32'h0C00_0020; // 0x40: jal 0x80
        img[17]   = 32'h1000_FFFF; // 0x44: beq $0,$0,-1
        img[32]   = 32'h03E0_0008; // 0x80: jr $31
        enter_reset(4'd0);
        release_reset();
        wait_retires("p3_retire_timeout", 7, 80);
        check("p3_bne_fall", fa[1], 32'h0000_3004);
        check("p3_j_target", fa[2], 32'h0000_0040);
        check("p3_jal_target", fa[3], 32'h0000_0080);
        check("p3_jr_return", fa[4], 32'h0000_0044);
        check("p3_beq_loop_a", fa[5], 32'h0000_0044);
        check("p3_beq_loop_b", fa[6], 32'h0000_0044);
        check("p3_bne_cycles", 32'(ret_cyc[0] - 1), 32'd3);
        check("p3_j_cycles", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
        check("p3_beq_cycles", 32'(ret_cyc[6] - ret_cyc[5]), 32'd3);
        check_reg("p3_r31", 5'd31, 32'h0000_0044);

        // $0 write discard and remaining ALU functions
        clear_img();
        img[PB+0] = 32'h2000_0009; // addi $0,$0,9
        img[PB+1] = 32'h0000_3021; // addu $6,$0,$0
        img[PB+2] = 32'h3401_0F0F; // ori  $1,$0,0x0F0F
        img[PB+3] = 32'h3402_00FF; // ori  $2,$0,0x00FF
        img[PB+4] = 32'h0022_1823; // subu $3,$1,$2
        img[PB+5] = 32'h0022_2024; // and  $4,$1,$2
        img[PB+6] = 32'h0022_2825; // or   $5,$1,$2
        img[PB+7] = 32'h0022_382A; // slt  $7,$1,$2
        img[PB+8] = 32'h0041_4023; // subu $8,$2,$1
        img[PB+9] = 32'hFC00_0000;
        enter_reset(4'd0);
        release_reset();
        wait_retires("p4_retire_timeout", 9, 120);
        check_reg("p4_r0", 5'd0, 32'h0);
        check_reg("p4_r6", 5'd6, 32'h0);
        check_reg("p4_subu", 5'd3, 32'h0000_0E10);
        check_reg("p4_and", 5'd4, 32'h0000_000F);
        check_reg("p4_or", 5'd5, 32'h0000_0FFF);
        check_reg("p4_slt", 5'd7, 32'h0);
        check_reg("p4_subu_neg", 5'd8, 32'hFFFF_F1F0);

        // illegal opcode
        clear_img();
        img[PB+0] = 32'hFC00_0000;
        enter_reset(4'd0);
        release_reset();
        tick();
        tick();
        check("ill_trap_decode", 32'(trap), 32'd0);
        tick();
        check("ill_trap_set", 32'(trap), 32'd1);
        repeat (5) tick();
        check("ill_req", 32'(bus.mem_req), 32'd0);
        check("ill_pc", PC, 32'h0000_3004);
        check("ill_trap_sticky", 32'(trap), 32'd1);
        check("ill_no_retire", 32'(rcount), 32'd0);

        // misaligned load
        clear_img();
        img[PB+0] = 32'h8C01_0002; // lw $1,2($0)
        enter_reset(4'd0);
        release_reset();
        repeat (3) tick();
        check("mis_trap_exec", 32'(trap), 32'd0);
        tick();
        check("mis_trap_set", 32'(trap), 32'd1);
        check("mis_req", 32'(bus.mem_req), 32'd0);
        repeat (3) tick();
        check("mis_accesses", 32'(ndone), 32'd1);
        check_reg("mis_r1", 5'd1, 32'h0);

        // asynchronous reset during a stalled store
        clear_img();
        img[PB+0] = 32'h3401_0005;
        img[PB+1] = 32'hAC01_0008;
        enter_reset(4'd2);
        release_reset();
        k = 0;
        while (!bus.mem_we && k < 60) begin
            tick();
            k++;
        end
        check("ar_store_seen", 32'(bus.mem_we), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_req", 32'(bus.mem_req), 32'd0);
        check("ar_we", 32'(bus.mem_we), 32'd0);
        check("ar_addr", bus.mem_addr, 32'h0);
        check("ar_wdata", bus.mem_wdata, 32'h0);
        check("ar_pc", PC, RPC);
        check("ar_retire", 32'(retire), 32'd0);
        check_reg("ar_r1", 5'd1, 32'h0);

        // asynchronous reset during a stalled fetch
        enter_reset(4'd2);
        release_reset();
        tick();
        check("af_req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("af_req", 32'(bus.mem_req), 32'd0);
        check("af_addr", bus.mem_addr, 32'h0);
        check("af_trap", 32'(trap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mccpu.md
# mccpu

Parametrised multi-cycle MIPS-subset core, next generation of the single-cycle `sccpu`. One shared memory port with a ready handshake replaces the separate instruction and data ports, so wait-stated memory is supported. A control FSM sequences each instruction over 3–5 states. It sits between the testbench/SoC memory model and the debug register-select interface, which keeps the same semantics as before.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- SP_INIT, 32'h0000_2ffc, reset value of $29; all other registers reset to 0.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory transaction request; registered.
- mem_we  output  1  1 = store, 0 = read (fetch or load); registered.
- mem_addr  output  32  byte address, word aligned; registered.
- mem_wdata  output  32  store data (rt); registered.
- mem_rdata  input  32  read data, valid when mem_ready=1.
- mem_ready  input  1  transaction completes at a rising edge where mem_req=1 and mem_ready=1.
- PC  output  32  current instruction address.
- retire  output  1  one-cycle pulse in the cycle after an instruction's last state.
- trap  output  1  sticky; set on an illegal opcode/funct or a misaligned lw/sw address.
- reg_sel  input  5  debug register index.
- reg_data  output  32  combinational read of register reg_sel; $0 reads 0.

## Operation
- ISA:
  - R-type: addu, subu, and, or, slt, sll (shamt), jr.
  - I-type: addi (sign-extended), ori (zero-extended), lw, sw, beq, bne.
  - J-type: j, jal.
- FSM states and transitions:
  - BOOT → FETCH.
  - FETCH → DECODE when the handshake completes; otherwise stay in FETCH. On completion: IR←mem_rdata, PC←PC+4.
  - DECODE: A←rs, B←rt, extended immediate computed. Go to TRAP if the op/funct is illegal, else EXEC.
  - EXEC, by instruction class:
    - ALU ops: ALUOut←result → WB.
    - lw/sw: address←rs+sext(imm). Go to TRAP if addr[1:0]≠0, else MEM.
    - beq/bne: if taken, PC←PC+(sext(imm)<<2); → FETCH.
    - j: PC←{PC[31:28], imm26, 2'b00} → FETCH.
    - jal: same as j, plus $31←PC (the address of the instruction after the jal) → FETCH.
    - jr: PC←rs → FETCH.
  - MEM: hold mem_req until ready.
    - lw → WB, capturing MDR←mem_rdata.
    - sw → FETCH.
  - WB: rd (R-type) or rt (I-type) ← ALUOut or MDR → FETCH.
  - TRAP: absorbing; mem_req=0, no register or PC writes. Exit only via rst.
- Register writes to $0 are discarded.
- Arithmetic:
  - All arithmetic is 32-bit, wrap-around, and raises no overflow trap.
  - slt is a signed compare.
  - sll shifts rt by shamt.
- Memory outputs:
  - mem_req is set on entry to FETCH or MEM.
  - mem_addr, mem_we and mem_wdata are loaded in the same cycle mem_req is set and held stable while mem_req=1.
  - mem_req clears in the cycle after completion.
- retire pulses once for every completed instruction and never in TRAP.

## Timing
- Reset values:
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, PC=RESET_PC, retire=0, trap=0.
  - Registers: $29=SP_INIT, all others 0.
  - State: BOOT.
- Reset is asynchronous: asserting rst mid-transaction drops mem_req immediately and aborts any pending write-back.
- First fetch: mem_req rises at the first rising edge after rst deasserts, with mem_addr=RESET_PC.
- Cycles per instruction with zero wait (mem_ready tied 1):
  - beq/bne, j, jal, jr: 3.
  - R-type, addi, ori, sw: 4.
  - lw: 5.
- Each wait cycle (mem_ready=0 while mem_req=1) adds one cycle to FETCH or MEM.
- Branch taken/not-taken cost is identical.
- mem_ready is ignored while mem_req=0.
- Debug read:
  - reg_data is combinational.
  - A write-back is visible on reg_data from the edge after WB.
  - On a simultaneous write and read of the same register, reg_data shows the old value until that edge.

## Test plan
- Reset with RESET_PC=32'h3000 and mem_ready=1 → first request has mem_addr=32'h3000, mem_we=0; $29 reads 32'h2ffc.
- Program `ori $1,$0,5; addi $2,$1,-7; slt $3,$2,$1; sll $4,$1,3` → $1=5, $2=32'hFFFF_FFFE, $3=1, $4=40; four retire pulses, 16 cycles.
- `sw $1,8($0); lw $5,8($0)` with mem_ready low for 2 cycles on every access:
  - store request shows mem_we=1, addr=8, wdata=5, with inputs held stable through the wait;
  - $5=5;
  - total 4+5+4×2=17 cycles.
- Branches and jumps:
  - `beq` taken with imm=-1 loops to itself; `bne` not taken falls through.
  - `jal` at 0x40 → $31=0x44; `jr $31` returns to 0x44.
- `addi $0,$0,9` → $0 still reads 0.
- Illegal opcode 6'h3F → trap=1 after DECODE, mem_req stays 0, PC frozen.
- Misaligned `lw $1,2($0)` → trap=1 in EXEC with no memory request.
- rst asserted mid-FETCH wait → all outputs return to their reset values immediately.
